// File: rtl/maxnet_cnt_if.sv
// Maxnet controller bundle: start request, PLU handshake, activation write enables, run status.
// Pure wiring, no latency of its own.
// No backpressure: plu_start/plu_done is a pulse handshake; the controller guards it with a watchdog.
interface maxnet_cnt_if #(
    parameter int N_UNITS = 4,
    parameter int IDX_W   = 2,
    parameter int ITER_W  = 5
);
    // requests and status flowing into the controller
    logic               start;
    logic               plu_done;
    logic [N_UNITS-1:0] nz_flags;

    // strobes and status driven by the controller
    logic               plu_start;
    logic               ld_we;
    logic               upd_we;
    logic               busy;
    logic               done;
    logic               winner_valid;
    logic [IDX_W-1:0]   winner_idx;
    logic               iter_limit;
    logic               plu_err;
    logic [ITER_W-1:0]  iter_cnt;

    // master: the iteration controller (initiator of the PLU handshake)
    modport master (
        input  start, plu_done, nz_flags,
        output plu_start, ld_we, upd_we, busy, done,
               winner_valid, winner_idx, iter_limit, plu_err, iter_cnt
    );

    // slave: the environment (PLU, activation registers, host)
    modport slave (
        output start, plu_done, nz_flags,
        input  plu_start, ld_we, upd_we, busy, done,
               winner_valid, winner_idx, iter_limit, plu_err, iter_cnt
    );
endinterface

// File: rtl/maxnet_cnt.sv
// Maxnet iteration controller: load activations, fire PLU passes until <=1 unit survives, limit or timeout.
// Latency: start -> ld_we +1 cycle, plu_start +2; plu_done -> upd_we +1; UPDATE -> CHECK -> FINISH 1 cycle each.
// No backpressure: start is ignored while busy; plu_done is only honoured in WAIT; a watchdog bounds WAIT.
module maxnet_cnt #(
    parameter int N_UNITS  = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    maxnet_cnt_if.master    bus
);
    localparam int WD_W = $clog2(WAIT_MAX + 1);
    localparam int PC_W = $clog2(N_UNITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FIRE   = 3'd2,
        S_WAIT   = 3'd3,
        S_UPDATE = 3'd4,
        S_CHECK  = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WD_W-1:0]    r_wdog;
    logic [WD_W-1:0]    w_wdog_inc;
    logic               w_wdog_expire;

    logic [PC_W-1:0]    w_popcnt;
    logic [IDX_W-1:0]   w_set_idx;
    logic               w_at_most_one;
    logic               w_exactly_one;
    logic               w_at_limit;

    logic               r_winner_valid;
    logic [IDX_W-1:0]   r_winner_idx;
    logic               r_iter_limit;
    logic               r_plu_err;
    logic [ITER_W-1:0]  r_iter_cnt;

    logic               w_plu_start;
    logic               w_ld_we;
    logic               w_upd_we;
    logic               w_busy;
    logic               w_done;

    // The watchdog expires on the WAIT cycle whose increment would reach WAIT_MAX.
    assign w_wdog_inc    = r_wdog + WD_W'(1);
    assign w_wdog_expire = (w_wdog_inc == WD_W'(WAIT_MAX));
    assign w_at_limit    = (r_iter_cnt == ITER_W'(MAX_ITER));
    assign w_at_most_one = (w_popcnt <= PC_W'(1));
    assign w_exactly_one = (w_popcnt == PC_W'(1));

    // Count surviving units and locate the set bit; the index is only meaningful when exactly one is set.
    always_comb begin
        w_popcnt  = '0;
        w_set_idx = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (bus.nz_flags[i]) begin
                w_popcnt  = w_popcnt + PC_W'(1);
                w_set_idx = IDX_W'(i);
            end
        end
    end

    // State register; rst dominates every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore decode of the strobes; illegal encodings fall back to IDLE with outputs low.
    always_comb begin
        w_state_nxt = r_state;
        w_plu_start = 1'b0;
        w_ld_we     = 1'b0;
        w_upd_we    = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld_we     = 1'b1;
                w_state_nxt = S_FIRE;
            end
            S_FIRE: begin
                w_plu_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // plu_done beats a watchdog expiring on the same edge
                if (bus.plu_done) begin
                    w_state_nxt = S_UPDATE;
                end else if (w_wdog_expire) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_UPDATE: begin
                w_upd_we    = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_at_most_one || w_at_limit) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_FIRE;
                end
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Watchdog: cleared when a pass is fired, counts WAIT cycles without plu_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_FIRE) begin
            r_wdog <= '0;
        end else if ((r_state == S_WAIT) && !bus.plu_done && !w_wdog_expire) begin
            r_wdog <= w_wdog_inc;
        end
    end

    // Run status: cleared on an accepted start, updated as the run progresses, held after FINISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner_valid <= 1'b0;
            r_winner_idx   <= '0;
            r_iter_limit   <= 1'b0;
            r_plu_err      <= 1'b0;
            r_iter_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_winner_valid <= 1'b0;
                        r_winner_idx   <= '0;
                        r_iter_limit   <= 1'b0;
                        r_plu_err      <= 1'b0;
                        r_iter_cnt     <= '0;
                    end
                end
                S_WAIT: begin
                    if (!bus.plu_done && w_wdog_expire) begin
                        r_plu_err <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_iter_cnt <= r_iter_cnt + ITER_W'(1);
                end
                S_CHECK: begin
                    // a settled winner (or an empty field) takes precedence over the pass limit
                    if (w_at_most_one) begin
                        r_winner_valid <= w_exactly_one;
                        r_winner_idx   <= w_exactly_one ? w_set_idx : '0;
                    end else if (w_at_limit) begin
                        r_iter_limit <= 1'b1;
                    end
                end
                S_LOAD, S_FIRE, S_FINISH: begin
                end
                default: begin
                    r_winner_valid <= 1'b0;
                    r_winner_idx   <= '0;
                    r_iter_limit   <= 1'b0;
                    r_plu_err      <= 1'b0;
                    r_iter_cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.plu_start    = w_plu_start;
    assign bus.ld_we        = w_ld_we;
    assign bus.upd_we       = w_upd_we;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.winner_valid = r_winner_valid;
    assign bus.winner_idx   = r_winner_idx;
    assign bus.iter_limit   = r_iter_limit;
    assign bus.plu_err      = r_plu_err;
    assign bus.iter_cnt     = r_iter_cnt;
endmodule

// File: tb/tb_maxnet_cnt.sv
// Directed bench for maxnet_cnt with a PLU responder and an activation-flag feeder.
// Expected run results are queued at launch and popped when done pulses.
// Every wait on the design is bounded; an expired bound counts as a failed check.
module tb_maxnet_cnt;
    localparam int N_UNITS  = 4;
    localparam int IDX_W    = 2;
    localparam int MAX_ITER = 16;
    localparam int ITER_W   = 5;
    localparam int WAIT_MAX = 15;

    typedef struct {
        logic              wv;
        logic [IDX_W-1:0]  idx;
        logic              lim;
        logic              err;
        logic [ITER_W-1:0] it;
        int                starts;
        int                upds;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    maxnet_cnt_if #(.N_UNITS(N_UNITS), .IDX_W(IDX_W), .ITER_W(ITER_W)) bus ();

    maxnet_cnt #(
        .N_UNITS (N_UNITS),
        .IDX_W   (IDX_W),
        .MAX_ITER(MAX_ITER),
        .ITER_W  (ITER_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    int               n_start  = 0;
    int               n_upd    = 0;
    int               base_start;
    int               base_upd;
    bit               plu_en    = 1'b1;
    int               plu_delay = 4;
    logic             model_done = 1'b0;
    logic             poke_done  = 1'b0;
    logic [N_UNITS-1:0] flags_drv = '0;
    logic [N_UNITS-1:0] flag_q[$];
    exp_t             sb_q[$];

    assign bus.plu_done = model_done | poke_done;
    assign bus.nz_flags = flags_drv;

    // PLU model: answers each plu_start with a plu_done pulse plu_delay cycles later
    initial begin
        forever begin
            @(negedge clk);
            if (plu_en && bus.plu_start === 1'b1) begin
                repeat (plu_delay) @(negedge clk);
                model_done = 1'b1;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Pulse counters and activation-register model: each upd_we loads the next flag pattern
    initial begin
        forever begin
            @(negedge clk);
            if (bus.plu_start === 1'b1) n_start++;
            if (bus.upd_we === 1'b1) begin
                n_upd++;
                if (flag_q.size() > 0) flags_drv = flag_q.pop_front();
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic wv, input int idx, input logic lim, input logic err,
                                input int it, input int starts, input int upds);
        exp_t e;
        e.wv = wv; e.idx = IDX_W'(idx); e.lim = lim; e.err = err;
        e.it = ITER_W'(it); e.starts = starts; e.upds = upds;
        return e;
    endfunction

    // pulse start for one cycle; returns at the negedge of the LOAD cycle
    task automatic launch(input exp_t e);
        if (e.starts >= 0) sb_q.push_back(e);
        base_start = n_start;
        base_upd   = n_upd;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_plu_start(input string tag, input int budget);
        int cyc = 0;
        while (bus.plu_start !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, bus.plu_start, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   cyc = 0;
        logic seen;
        exp_t e;
        while (bus.done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        seen = (bus.done === 1'b1);
        chk($sformatf("%s.done", tag), seen, 1'b1);
        chk($sformatf("%s.sb_has_entry", tag), sb_q.size() != 0, 1'b1);
        if (seen && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s.winner_valid", tag), bus.winner_valid, e.wv);
            chk($sformatf("%s.winner_idx", tag), bus.winner_idx, e.idx);
            chk($sformatf("%s.iter_limit", tag), bus.iter_limit, e.lim);
            chk($sformatf("%s.plu_err", tag), bus.plu_err, e.err);
            chk($sformatf("%s.iter_cnt", tag), bus.iter_cnt, e.it);
            chk($sformatf("%s.plu_starts", tag), n_start - base_start, e.starts);
            chk($sformatf("%s.upd_wes", tag), n_upd - base_upd, e.upds);
        end
        @(negedge clk);
        chk($sformatf("%s.idle_after", tag), bus.busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s.busy", tag), bus.busy, 1'b0);
        chk($sformatf("%s.plu_start", tag), bus.plu_start, 1'b0);
        chk($sformatf("%s.ld_we", tag), bus.ld_we, 1'b0);
        chk($sformatf("%s.upd_we", tag), bus.upd_we, 1'b0);
        chk($sformatf("%s.done", tag), bus.done, 1'b0);
        chk($sformatf("%s.winner_valid", tag), bus.winner_valid, 1'b0);
        chk($sformatf("%s.winner_idx", tag), bus.winner_idx, 0);
        chk($sformatf("%s.iter_limit", tag), bus.iter_limit, 1'b0);
        chk($sformatf("%s.plu_err", tag), bus.plu_err, 1'b0);
        chk($sformatf("%s.iter_cnt", tag), bus.iter_cnt, 0);
    endtask

    initial begin
        int   cyc;
        logic busy_seen;
        int   s0;

        bus.start = 1'b0;
        rst       = 1'b1;

        // 1. reset, then idle with start low
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        s0 = n_start;
        busy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            busy_seen = busy_seen | bus.busy;
        end
        chk("idle.busy_seen", busy_seen, 1'b0);
        chk("idle.plu_starts", n_start - s0, 0);

        // 2. single pass, winner is unit 2; also the start -> ld_we -> plu_start latency
        flag_q.push_back(4'b0100);
        launch(mk(1'b1, 2, 1'b0, 1'b0, 1, 1, 1));
        chk("t2.ld_we_k1", bus.ld_we, 1'b1);
        chk("t2.busy_k1", bus.busy, 1'b1);
        @(negedge clk);
        chk("t2.plu_start_k2", bus.plu_start, 1'b1);
        wait_done("t2", 100);
        repeat (5) @(negedge clk);
        chk("t2.hold_winner_valid", bus.winner_valid, 1'b1);
        chk("t2.hold_winner_idx", bus.winner_idx, 2);
        chk("t2.hold_iter_cnt", bus.iter_cnt, 1);

        // 3. three passes narrowing down to unit 3
        flag_q.push_back(4'b1111);
        flag_q.push_back(4'b1011);
        flag_q.push_back(4'b1000);
        launch(mk(1'b1, 3, 1'b0, 1'b0, 3, 3, 3));
        wait_done("t3", 300);

        // 4. two units never resolve: pass limit
        for (int i = 0; i < MAX_ITER; i++) flag_q.push_back(4'b0011);
        launch(mk(1'b0, 0, 1'b1, 1'b0, MAX_ITER, MAX_ITER, MAX_ITER));
        wait_done("t4", 2000);

        // 5a. PLU never answers: watchdog ends the run 15 cycles after WAIT entry
        plu_en = 1'b0;
        launch(mk(1'b0, 0, 1'b0, 1'b1, 0, 1, 0));
        wait_plu_start("t5a.plu_start", 10);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t5a.fire_to_done_cycles", cyc, WAIT_MAX + 1);
        wait_done("t5a", 5);

        // 5b. plu_done on the last WAIT cycle still wins over the watchdog
        plu_en    = 1'b1;
        plu_delay = WAIT_MAX;
        flag_q.push_back(4'b0001);
        launch(mk(1'b1, 0, 1'b0, 1'b0, 1, 1, 1));
        wait_done("t5b", 100);

        // 6a. start during WAIT and plu_done during CHECK are ignored
        plu_delay = 4;
        flag_q.push_back(4'b1111);
        flag_q.push_back(4'b0010);
        launch(mk(1'b1, 1, 1'b0, 1'b0, 2, 2, 2));
        wait_plu_start("t6a.plu_start", 10);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.upd_we !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6a.upd_we_seen", bus.upd_we, 1'b1);
        @(negedge clk);
        poke_done = 1'b1;
        @(negedge clk);
        poke_done = 1'b0;
        wait_done("t6a", 100);

        // 6b. reset in WAIT of the second pass aborts the run
        for (int i = 0; i < 4; i++) flag_q.push_back(4'b1111);
        launch(mk(1'b0, 0, 1'b0, 1'b0, 0, -1, 0));
        wait_plu_start("t6b.plu_start1", 10);
        @(negedge clk);
        wait_plu_start("t6b.plu_start2", 50);
        @(negedge clk);
        chk("t6b.iter_before_rst", bus.iter_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("t6b.after_rst");
        rst = 1'b0;
        flag_q.delete();
        repeat (8) @(negedge clk);
        chk("t6b.stray_done_ignored", bus.busy, 1'b0);

        // 6c. clean run after the abort
        flag_q.push_back(4'b1000);
        launch(mk(1'b1, 3, 1'b0, 1'b0, 1, 1, 1));
        chk("t6c.iter_cnt_at_load", bus.iter_cnt, 0);
        wait_done("t6c", 100);

        // 7. every unit dies: no winner, index cleared, done still pulses
        flag_q.push_back(4'b0000);
        launch(mk(1'b0, 0, 1'b0, 1'b0, 1, 1, 1));
        wait_done("t7", 100);

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
